// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage; registers EX outputs, completes loads, drives WB and forwarding buses
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_ID_WD = 38,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [31:0]             hold_data_q, hold_data_d;

    logic [31:0] mem_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic [2:0]  mem_op;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        is_load;
    logic [1:0]  addr_lo;
    logic [31:0] rdata_eff;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_stall;

    assign {mem_pc, data_ram_en, data_ram_wen, mem_op, sel_rf_res, rf_we, rf_waddr, ex_result} = bus_q;
    assign is_load      = data_ram_en && (data_ram_wen == 4'b0000);
    assign addr_lo      = ex_result[1:0];
    assign unused_stall = ^{stall[STALL_WD-1:5], stall[2:0]};

    // next stage register: capture EX, insert bubble, or hold; latch first-cycle load data while held
    always_comb begin
        bus_d        = bus_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (!stall[3]) begin
            bus_d        = ex_to_mem_bus;
            hold_valid_d = 1'b0;
        end else if (!stall[4]) begin
            bus_d        = '0;
            hold_valid_d = 1'b0;
        end else if (!hold_valid_q && is_load) begin
            hold_data_d  = data_sram_rdata;
            hold_valid_d = 1'b1;
        end
    end

    // stage register and held load data, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            bus_q        <= bus_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // pick the byte/halfword addressed by the low address bits and extend it per mem_op
    always_comb begin
        rdata_eff = hold_valid_q ? hold_data_q : data_sram_rdata;
        load_byte = rdata_eff[{addr_lo, 3'b000} +: 8];
        load_half = addr_lo[1] ? rdata_eff[31:16] : rdata_eff[15:0];
        load_data = (mem_op == OP_LB)  ? {{24{load_byte[7]}}, load_byte} :
                    (mem_op == OP_LBU) ? {24'b0, load_byte} :
                    (mem_op == OP_LH)  ? {{16{load_half[15]}}, load_half} :
                    (mem_op == OP_LHU) ? {16'b0, load_half} :
                                         rdata_eff;
    end

    // writeback value and the two outgoing buses
    always_comb begin
        rf_wdata      = (sel_rf_res && is_load) ? load_data : ex_result;
        mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, rf_wdata};
        mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural model
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic [78:0] ex_bus = '0;
    logic [31:0] rdata = '0;
    logic [69:0] wb_bus;
    logic [37:0] id_bus;

    int checks = 0;
    int failures = 0;

    // model: instruction occupying MEM, cycles it has been held, rdata seen in its first cycle
    logic [78:0] m_bus = '0;
    int          m_age = 0;
    logic [31:0] m_first = '0;

    mem_stage dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .ex_to_mem_bus(ex_bus),
        .data_sram_rdata(rdata),
        .mem_to_wb_bus(wb_bus),
        .mem_to_id_bus(id_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [78:0] mk(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                       input logic [2:0] op, input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {pc, en, wen, op, sel, we, wa, res};
    endfunction

    function automatic logic [78:0] rnd_bus();
        logic [95:0] r = {$urandom, $urandom, $urandom};
        return r[78:0];
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] b = (d >> (8 * a)) & 32'h000000FF;
        logic [31:0] h = (d >> (16 * a[1])) & 32'h0000FFFF;
        if (op == 3'd1) return b[7] ? (b | 32'hFFFFFF00) : b;
        if (op == 3'd2) return b;
        if (op == 3'd3) return h[15] ? (h | 32'hFFFF0000) : h;
        if (op == 3'd4) return h;
        return d;
    endfunction

    function automatic logic [69:0] model_wb();
        logic [31:0] eff = (m_age > 0) ? m_first : rdata;
        logic load = m_bus[46] && (m_bus[45:42] == 4'b0000);
        logic [31:0] wd = (m_bus[38] && load) ? extract(m_bus[41:39], m_bus[1:0], eff) : m_bus[31:0];
        return {m_bus[78:47], m_bus[37], m_bus[36:32], wd};
    endfunction

    task automatic apply(input logic r, input logic [5:0] s, input logic [78:0] b, input logic [31:0] d,
                         input string tag);
        logic [69:0] e;
        rst = r;
        stall = s;
        ex_bus = b;
        rdata = d;
        #1;
        if (!rst) begin
            m_bus = '0;
            m_age = 0;
            m_first = '0;
        end
        e = model_wb();
        check({tag, "_wb"}, wb_bus, e);
        check({tag, "_id"}, {32'b0, id_bus}, {32'b0, e[37:0]});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_bus = '0;
            m_age = 0;
            m_first = '0;
        end else if (!stall[3]) begin
            m_bus = ex_bus;
            m_age = 0;
        end else if (!stall[4]) begin
            m_bus = '0;
            m_age = 0;
        end else begin
            if (m_age == 0) m_first = rdata;
            m_age++;
        end
        @(negedge clk);
    endtask

    logic [2:0]  ld_op  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [31:0] ld_adr [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
    logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

    initial begin
        logic [78:0] b;
        logic [5:0]  s;
        int          k;
        #2;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 6'($urandom), rnd_bus(), $urandom, "reset");
            check("reset_wb_zero", wb_bus, '0);
            check("reset_id_zero", {32'b0, id_bus}, '0);
            tick();
        end

        apply(1'b1, 6'b0, mk(32'hBFC00010, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 5'd8, 32'h12345678), $urandom, "alu_in");
        tick();
        apply(1'b1, 6'b0, '0, $urandom, "alu");
        check("alu_wb", wb_bus, {32'hBFC00010, 1'b1, 5'd8, 32'h12345678});
        check("alu_fwd", {32'b0, id_bus}, {32'b0, 1'b1, 5'd8, 32'h12345678});

        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 6'b0, mk(32'h00400100, 1'b1, 4'h0, ld_op[i], 1'b1, 1'b1, 5'd3, ld_adr[i]), $urandom, "ld_in");
            tick();
            apply(1'b1, 6'b0, '0, 32'h80FF7F01, "ld");
            check($sformatf("ld_op%0d", ld_op[i]), wb_bus[31:0], ld_exp[i]);
        end

        apply(1'b1, 6'b0, mk(32'h00400200, 1'b1, 4'h0, 3'd0, 1'b1, 1'b1, 5'd4, 32'h2000), $urandom, "hold_in");
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 6'b011111, rnd_bus(), (i == 0) ? 32'hCAFEF00D : 32'hDEADBEEF, "hold");
            check("hold_wdata", wb_bus[31:0], 32'hCAFEF00D);
            tick();
        end
        apply(1'b1, 6'b0, rnd_bus(), 32'hDEADBEEF, "release");
        check("release_wdata", wb_bus[31:0], 32'hCAFEF00D);
        tick();

        apply(1'b1, 6'b001000, rnd_bus(), $urandom, "bub_in");
        tick();
        apply(1'b1, 6'b0, mk(32'h00400020, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 5'd9, 32'hA5A5A5A5), $urandom, "bub");
        check("bubble_zero", wb_bus, '0);
        tick();
        apply(1'b1, 6'b0, '0, $urandom, "cap");
        check("bubble_next", wb_bus, {32'h00400020, 1'b1, 5'd9, 32'hA5A5A5A5});
        tick();

        apply(1'b1, 6'b0, mk(32'h00400300, 1'b1, 4'h0, 3'd0, 1'b1, 1'b1, 5'd7, 32'h3000), $urandom, "ar_in");
        tick();
        apply(1'b1, 6'b011111, rnd_bus(), 32'h11112222, "ar_hold");
        tick();
        apply(1'b1, 6'b011111, rnd_bus(), 32'h33334444, "ar_held");
        check("ar_held", wb_bus[31:0], 32'h11112222);
        #2;
        rst = 1'b0;
        #1;
        m_bus = '0;
        m_age = 0;
        m_first = '0;
        check("ar_zero_wb", wb_bus, '0);
        check("ar_zero_id", {32'b0, id_bus}, '0);
        tick();
        apply(1'b1, 6'b0, mk(32'h00400304, 1'b1, 4'h0, 3'd0, 1'b1, 1'b1, 5'd7, 32'h3004), $urandom, "ar_in2");
        tick();
        apply(1'b1, 6'b0, '0, 32'h5555AAAA, "ar_fresh");
        check("ar_fresh", wb_bus[31:0], 32'h5555AAAA);
        tick();

        for (int i = 0; i < 400; i++) begin
            b = rnd_bus();
            if ($urandom_range(0, 3) != 0) b[46] = 1'b1;
            if ($urandom_range(0, 2) != 0) b[45:42] = 4'h0;
            k = $urandom_range(0, 9);
            s = (k < 6) ? 6'b000000 : (k < 8) ? 6'b011111 : (k == 8) ? 6'b001111 : 6'($urandom);
            apply(($urandom_range(0, 49) != 0), s, b, $urandom, "rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
